apb_uart_slave: RTL and testbench

APB slave register front-end for the UART receive path. It sits directly downstream of the receiver block. It consumes the receiver's rx_data, data_ready, overrun_error and framing_error outputs. It drives the receiver's data_size, data_period and data_read inputs from a small APB-mapped register file.

---
 rtl/apb_uart_slave_if.sv | 22 ++
 rtl/apb_uart_slave.sv | 190 +++++++++++++++++++
 tb/tb_apb_uart_slave.sv | 212 +++++++++++++++++++++
 3 files changed

// File: rtl/apb_uart_slave_if.sv
// APB bus bundle between a bus master and the UART receive-path register front-end.
interface apb_uart_slave_if #(
  parameter int unsigned ADDR_W = 3
) ();
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [ADDR_W-1:0] paddr;
  logic [7:0]        pwdata;
  logic [7:0]        prdata;
  logic              pslverr;

  modport master (
    output psel, penable, pwrite, paddr, pwdata,
    input  prdata, pslverr
  );

  modport slave (
    input  psel, penable, pwrite, paddr, pwdata,
    output prdata, pslverr
  );
endinterface

// File: rtl/apb_uart_slave.sv
// APB register front-end for the UART receiver: status/error/data readback and
// data_size/data_period configuration, zero-wait-state APB with error response.
module apb_uart_slave #(
  parameter int unsigned ADDR_W     = 3,
  parameter int unsigned PERIOD_RST = 10,
  parameter int unsigned SIZE_RST   = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  apb_uart_slave_if.slave       apb,
  input  logic [7:0]            rx_data,
  input  logic                  data_ready,
  input  logic                  overrun_error,
  input  logic                  framing_error,
  output logic                  data_read,
  output logic [3:0]            data_size,
  output logic [13:0]           data_period
);

  localparam int unsigned DATA_W   = 8;
  localparam int unsigned SIZE_W   = 4;
  localparam int unsigned PERIOD_W = 14;

  localparam logic [ADDR_W-1:0] A_STATUS    = ADDR_W'(0);
  localparam logic [ADDR_W-1:0] A_ERROR     = ADDR_W'(1);
  localparam logic [ADDR_W-1:0] A_PERIOD_LO = ADDR_W'(2);
  localparam logic [ADDR_W-1:0] A_PERIOD_HI = ADDR_W'(3);
  localparam logic [ADDR_W-1:0] A_SIZE      = ADDR_W'(4);
  localparam logic [ADDR_W-1:0] A_RXDATA    = ADDR_W'(6);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    ERR   = 2'd3
  } state_t;

  state_t              state_q;
  state_t              state_nxt;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   prdata_q;
  logic [SIZE_W-1:0]   size_q;
  logic [PERIOD_W-1:0] period_q;

  logic                setup_c;
  logic                access_c;
  logic                mapped_c;
  logic                writable_c;
  logic [DATA_W-1:0]   rx_masked_c;
  logic [DATA_W-1:0]   rd_mux_c;
  logic                load_rd_c;
  logic                wr_en_c;
  logic                pslverr_c;
  logic                data_read_c;

  assign setup_c  = apb.psel && !apb.penable;
  assign access_c = apb.psel && apb.penable;

  // Receive byte trimmed to the configured frame width.
  always_comb begin
    rx_masked_c = rx_data;
    if (size_q == SIZE_W'(5)) begin
      rx_masked_c = {3'b000, rx_data[4:0]};
    end else if (size_q == SIZE_W'(7)) begin
      rx_masked_c = {1'b0, rx_data[6:0]};
    end
  end

  // Address decode and read mux, evaluated on the setup-phase address.
  always_comb begin
    mapped_c   = 1'b0;
    writable_c = 1'b0;
    rd_mux_c   = '0;
    case (apb.paddr)
      A_STATUS: begin
        mapped_c = 1'b1;
        rd_mux_c = {7'b0, data_ready};
      end
      A_ERROR: begin
        mapped_c = 1'b1;
        rd_mux_c = {6'b0, overrun_error, framing_error};
      end
      A_PERIOD_LO: begin
        mapped_c   = 1'b1;
        writable_c = 1'b1;
        rd_mux_c   = period_q[7:0];
      end
      A_PERIOD_HI: begin
        mapped_c   = 1'b1;
        writable_c = 1'b1;
        rd_mux_c   = {2'b00, period_q[13:8]};
      end
      A_SIZE: begin
        mapped_c   = 1'b1;
        writable_c = 1'b1;
        rd_mux_c   = {4'b0000, size_q};
      end
      A_RXDATA: begin
        mapped_c = 1'b1;
        rd_mux_c = rx_masked_c;
      end
      default: begin
        mapped_c   = 1'b0;
        writable_c = 1'b0;
        rd_mux_c   = '0;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // FSM next state: every non-idle state is the single access cycle.
  always_comb begin
    state_nxt = IDLE;
    case (state_q)
      IDLE: begin
        if (setup_c) begin
          if (apb.pwrite) begin
            state_nxt = writable_c ? WRITE : ERR;
          end else begin
            state_nxt = mapped_c ? READ : ERR;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // FSM outputs: qualified by the live access phase so a dropped psel aborts.
  always_comb begin
    load_rd_c   = 1'b0;
    wr_en_c     = 1'b0;
    pslverr_c   = 1'b0;
    data_read_c = 1'b0;
    case (state_q)
      IDLE:  load_rd_c   = setup_c && !apb.pwrite && mapped_c;
      READ:  data_read_c = access_c && (addr_q == A_RXDATA);
      WRITE: wr_en_c     = access_c;
      ERR:   pslverr_c   = access_c;
      default: begin
        load_rd_c   = 1'b0;
        wr_en_c     = 1'b0;
        pslverr_c   = 1'b0;
        data_read_c = 1'b0;
      end
    endcase
  end

  // Read data captured at setup, cleared on every other edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      prdata_q <= '0;
      addr_q   <= '0;
    end else begin
      prdata_q <= load_rd_c ? rd_mux_c : '0;
      if (state_q == IDLE && setup_c) begin
        addr_q <= apb.paddr;
      end
    end
  end

  // Configuration registers commit on the edge ending the access phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      period_q <= PERIOD_W'(PERIOD_RST);
      size_q   <= SIZE_W'(SIZE_RST);
    end else if (wr_en_c) begin
      case (addr_q)
        A_PERIOD_LO: period_q[7:0]  <= apb.pwdata;
        A_PERIOD_HI: period_q[13:8] <= apb.pwdata[5:0];
        A_SIZE:      size_q         <= apb.pwdata[3:0];
        default:     period_q       <= period_q;
      endcase
    end
  end

  assign apb.prdata  = prdata_q;
  assign apb.pslverr = pslverr_c;
  assign data_read   = data_read_c;
  assign data_size   = size_q;
  assign data_period = period_q;

endmodule

// File: tb/tb_apb_uart_slave.sv
// Directed bench for apb_uart_slave: transaction-level register model checked
// every cycle, plus literal expectations on key readbacks.
module tb_apb_uart_slave;
  localparam int unsigned ADDR_W = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        data_ready;
  logic        overrun_error;
  logic        framing_error;
  logic        data_read;
  logic [3:0]  data_size;
  logic [13:0] data_period;

  always #5 clk = ~clk;

  apb_uart_slave_if #(.ADDR_W(ADDR_W)) apb ();

  apb_uart_slave #(
    .ADDR_W(ADDR_W), .PERIOD_RST(10), .SIZE_RST(8)
  ) dut (
    .clk(clk), .rst(rst), .apb(apb),
    .rx_data(rx_data), .data_ready(data_ready),
    .overrun_error(overrun_error), .framing_error(framing_error),
    .data_read(data_read), .data_size(data_size), .data_period(data_period)
  );

  int checks = 0;
  int errors = 0;

  // Model of the register file and of the transfer currently on the bus.
  logic [13:0] m_period;
  logic [3:0]  m_size;
  bit          chk_en     = 1'b0;
  bit          post_setup = 1'b0;
  bit          acc_valid  = 1'b0;
  logic [7:0]  exp_rdata  = 8'h00;
  bit          exp_err    = 1'b0;
  bit          exp_rd     = 1'b0;

  logic [7:0]  rd;
  logic        err;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_read(input logic [2:0] a);
    case (a)
      3'd0: return {7'b0, data_ready};
      3'd1: return {6'b0, overrun_error, framing_error};
      3'd2: return m_period[7:0];
      3'd3: return {2'b0, m_period[13:8]};
      3'd4: return {4'b0, m_size};
      3'd6: begin
        if (m_size == 4'd5) return rx_data & 8'h1F;
        if (m_size == 4'd7) return rx_data & 8'h7F;
        return rx_data;
      end
      default: return 8'h00;
    endcase
  endfunction

  function automatic bit m_illegal(input bit w, input logic [2:0] a);
    if (a == 3'd5 || a == 3'd7) return 1'b1;
    return w && !(a == 3'd2 || a == 3'd3 || a == 3'd4);
  endfunction

  // Per-cycle comparison of every DUT output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("prdata", apb.prdata, post_setup ? exp_rdata : 8'h00);
      check("pslverr", apb.pslverr, acc_valid && exp_err);
      check("data_read", data_read, acc_valid && exp_rd);
      check("data_period", data_period, m_period);
      check("data_size", data_size, m_size);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One APB transfer; drop=1 releases psel during the access phase.
  task automatic xfer(input bit w, input logic [2:0] a, input logic [7:0] d,
                      input bit drop, output logic [7:0] rdata, output logic rerr);
    bit ill;
    ill = m_illegal(w, a);
    apb.psel    = 1'b1;
    apb.penable = 1'b0;
    apb.pwrite  = w;
    apb.paddr   = a;
    apb.pwdata  = d;
    exp_rdata   = (w || ill) ? 8'h00 : m_read(a);
    exp_err     = ill;
    exp_rd      = !w && !ill && (a == 3'd6);
    step();
    post_setup  = 1'b1;
    acc_valid   = !drop;
    apb.psel    = !drop;
    apb.penable = 1'b1;
    #1;
    rdata = apb.prdata;
    rerr  = apb.pslverr;
    step();
    post_setup  = 1'b0;
    acc_valid   = 1'b0;
    if (!drop && w && !ill) begin
      case (a)
        3'd2:    m_period[7:0]  = d;
        3'd3:    m_period[13:8] = d[5:0];
        default: m_size         = d[3:0];
      endcase
    end
    apb.psel    = 1'b0;
    apb.penable = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    apb.psel = 1'b0; apb.penable = 1'b0; apb.pwrite = 1'b0;
    apb.paddr = '0;  apb.pwdata = 8'h00;
    rx_data = 8'h00; data_ready = 1'b0; overrun_error = 1'b0; framing_error = 1'b0;
    m_period = 14'd10;
    m_size   = 4'd8;
    step();
    step();
    rst = 1'b0;
    chk_en = 1'b1;
    step();

    // Reset values
    xfer(1'b0, 3'd2, 8'h00, 1'b0, rd, err); check("rst_period_lo", rd, 8'h0A);
    xfer(1'b0, 3'd3, 8'h00, 1'b0, rd, err); check("rst_period_hi", rd, 8'h00);
    xfer(1'b0, 3'd4, 8'h00, 1'b0, rd, err); check("rst_size", rd, 8'h08);
    check("rst_pslverr", err, 1'b0);

    // Period write/readback
    xfer(1'b1, 3'd2, 8'h34, 1'b0, rd, err);
    xfer(1'b1, 3'd3, 8'hFF, 1'b0, rd, err);
    step();
    check("period_lit", data_period, 14'h3F34);
    xfer(1'b0, 3'd3, 8'h00, 1'b0, rd, err); check("period_hi_rb", rd, 8'h3F);

    // RXDATA with 7-bit frames
    xfer(1'b1, 3'd4, 8'h07, 1'b0, rd, err);
    rx_data = 8'hD5; data_ready = 1'b1;
    step();
    xfer(1'b0, 3'd0, 8'h00, 1'b0, rd, err); check("status_lit", rd, 8'h01);
    xfer(1'b0, 3'd6, 8'h00, 1'b0, rd, err); check("rx7_lit", rd, 8'h55);

    // Error flags
    framing_error = 1'b1; overrun_error = 1'b1;
    step();
    xfer(1'b0, 3'd1, 8'h00, 1'b0, rd, err); check("error_lit", rd, 8'h03);

    // Illegal accesses
    xfer(1'b1, 3'd0, 8'hAA, 1'b0, rd, err); check("ill_w0_err", err, 1'b1); check("ill_w0_rd", rd, 8'h00);
    xfer(1'b1, 3'd6, 8'hAA, 1'b0, rd, err); check("ill_w6_err", err, 1'b1);
    xfer(1'b0, 3'd5, 8'h00, 1'b0, rd, err); check("ill_r5_err", err, 1'b1); check("ill_r5_rd", rd, 8'h00);
    xfer(1'b0, 3'd7, 8'h00, 1'b0, rd, err); check("ill_r7_err", err, 1'b1);
    step();

    // Back-to-back: size 5 then masked RXDATA read
    rx_data = 8'hFF;
    xfer(1'b1, 3'd4, 8'h05, 1'b0, rd, err);
    xfer(1'b0, 3'd6, 8'h00, 1'b0, rd, err); check("rx5_lit", rd, 8'h1F);

    // Upper SIZE bits ignored; size 3 passes rx_data unmasked
    rx_data = 8'hA7;
    xfer(1'b1, 3'd4, 8'hF3, 1'b0, rd, err);
    xfer(1'b0, 3'd6, 8'h00, 1'b0, rd, err); check("rx3_lit", rd, 8'hA7);

    // penable without setup is ignored
    apb.psel = 1'b1; apb.penable = 1'b1; apb.pwrite = 1'b1; apb.paddr = 3'd2; apb.pwdata = 8'h77;
    step();
    apb.psel = 1'b0; apb.penable = 1'b0;
    step();

    // psel dropped in access: no commit, no data_read, no error
    xfer(1'b1, 3'd2, 8'h11, 1'b1, rd, err);
    xfer(1'b0, 3'd6, 8'h00, 1'b1, rd, err);
    xfer(1'b0, 3'd5, 8'h00, 1'b1, rd, err); check("drop_err", err, 1'b0);
    step();

    // Reset during setup of a write to PERIOD_LO
    apb.psel = 1'b1; apb.penable = 1'b0; apb.pwrite = 1'b1; apb.paddr = 3'd2; apb.pwdata = 8'h99;
    rst = 1'b1;
    step();
    m_period = 14'd10;
    m_size   = 4'd8;
    rst = 1'b0;
    apb.penable = 1'b1;
    step();
    apb.psel = 1'b0; apb.penable = 1'b0;
    step();
    check("rst_mid_period", data_period, 14'd10);
    xfer(1'b0, 3'd2, 8'h00, 1'b0, rd, err); check("rst_mid_rb", rd, 8'h0A);
    step();

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
